dma_w_burst_split: RTL and testbench

Upstream feeder for the DMA AXI write engine. It takes a transfer request (start address, total beat count) plus a stream of data beats from the native databus side. Beats are buffered in an internal FIFO. The transfer is split into AXI INCR bursts that never cross a 4 KB boundary and never exceed the FIFO depth. Each burst is presented to the write engine only once all of its beats are buffered, because the engine consumes one beat per cycle in which the slave asserts wready and cannot stall for data.

---
 rtl/dma_w_burst_split.sv | 202 ++++++++++++++++++++
 tb/tb_dma_w_burst_split.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_w_burst_split.sv
`default_nettype none
// ============================================================================
// Module   : dma_w_burst_split
// Purpose  : Buffers native-bus data beats in a FIFO and splits a DMA write
//            transfer into AXI INCR bursts. A burst never crosses a 4 KB
//            boundary and never exceeds the FIFO depth. A burst is offered to
//            the write engine only once all of its beats are buffered, because
//            the engine drains one beat per wready and cannot stall for data.
// Ports    : clk, rst (async, active-high)
//            cfg_start/cfg_addr/cfg_nbeats -> transfer request; busy, done
//            in_valid/in_data/in_strb/in_ready -> beat input into the FIFO
//            w_valid/w_addr/w_len/w_wdata/w_wstrb -> burst to write engine
//            w_ready (beat consumed), w_dma_ready (engine idle)
// Revision : 1.0 - initial release
// ============================================================================
module dma_w_burst_split #(
    parameter int DMA_DATA_WIDTH  = 32,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int NBEATS_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [NBEATS_W-1:0]         cfg_nbeats,
    output logic                        busy,
    output logic                        done,
    input  logic                        in_valid,
    input  logic [DMA_DATA_WIDTH-1:0]   in_data,
    input  logic [DMA_DATA_WIDTH/8-1:0] in_strb,
    output logic                        in_ready,
    output logic                        w_valid,
    output logic [ADDR_W-1:0]           w_addr,
    output logic [LEN_W-1:0]            w_len,
    output logic [DMA_DATA_WIDTH-1:0]   w_wdata,
    output logic [DMA_DATA_WIDTH/8-1:0] w_wstrb,
    input  logic                        w_ready,
    input  logic                        w_dma_ready
);

    localparam int c_STRB_W = DMA_DATA_WIDTH / 8;
    localparam int c_SZ     = $clog2(c_STRB_W);
    localparam int c_DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int c_CNT_W  = FIFO_DEPTH_LOG2 + 1;
    // Wide enough to hold the remaining count and the 4 KB beat budget (4096)
    localparam int c_CALC_W = ((NBEATS_W > 13) ? NBEATS_W : 13) + 1;

    typedef enum logic [2:0] {
        c_ST_IDLE      = 3'd0,
        c_ST_CALC      = 3'd1,
        c_ST_WAIT_DATA = 3'd2,
        c_ST_BURST     = 3'd3,
        c_ST_WAIT_IDLE = 3'd4,
        c_ST_FIN       = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Beat FIFO
    // ------------------------------------------------------------------
    logic [DMA_DATA_WIDTH-1:0]  r_mem_data [c_DEPTH];
    logic [c_STRB_W-1:0]        r_mem_strb [c_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       w_push;
    logic                       w_pop;

    assign in_ready = (r_count != c_CNT_W'(c_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == c_ST_BURST) && w_ready;
    assign w_wdata  = r_mem_data[r_rd_ptr];
    assign w_wstrb  = r_mem_strb[r_rd_ptr];

    // Storage needs no reset: contents are only observed behind a valid count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_strb[r_wr_ptr] <= in_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst length = min(remaining, beats to 4 KB boundary, FIFO depth)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   r_addr;
    logic [NBEATS_W-1:0] r_remaining;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [LEN_W-1:0]    r_w_len;
    logic [c_CNT_W-1:0]  r_len;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [c_CALC_W-1:0] w_rem_ext;
    logic [c_CALC_W-1:0] w_bnd_beats;
    logic [c_CALC_W-1:0] w_len_calc;

    assign w_rem_ext   = c_CALC_W'(r_remaining);
    assign w_bnd_beats = c_CALC_W'((13'd4096 - {1'b0, r_addr[11:0]}) >> c_SZ);

    always_comb begin
        w_len_calc = c_CALC_W'(c_DEPTH);
        if (w_bnd_beats < w_len_calc) w_len_calc = w_bnd_beats;
        if (w_rem_ext < w_len_calc)   w_len_calc = w_rem_ext;
    end

    assign w_addr = r_w_addr;
    assign w_len  = r_w_len;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start)
                    w_state_next = (cfg_nbeats == '0) ? c_ST_FIN : c_ST_CALC;
            end
            c_ST_CALC:      w_state_next = c_ST_WAIT_DATA;
            c_ST_WAIT_DATA: begin
                if ((r_count >= r_len) && w_dma_ready) w_state_next = c_ST_BURST;
            end
            c_ST_BURST: begin
                w_valid = 1'b1;
                if (w_ready && (r_beat_cnt == r_w_len)) w_state_next = c_ST_WAIT_IDLE;
            end
            c_ST_WAIT_IDLE: begin
                // Engine idle again means the previous write response is done
                if (w_dma_ready)
                    w_state_next = (r_remaining != '0) ? c_ST_CALC : c_ST_FIN;
            end
            c_ST_FIN: begin
                done         = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_w_addr    <= '0;
            r_w_len     <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_start) begin
                        r_addr      <= cfg_addr;
                        r_remaining <= cfg_nbeats;
                    end
                end
                c_ST_CALC: begin
                    r_w_addr    <= r_addr;
                    r_w_len     <= LEN_W'(w_len_calc - c_CALC_W'(1));
                    r_len       <= c_CNT_W'(w_len_calc);
                    r_addr      <= r_addr + (ADDR_W'(w_len_calc) << c_SZ);
                    r_remaining <= r_remaining - NBEATS_W'(w_len_calc);
                    r_beat_cnt  <= '0;
                end
                c_ST_BURST: begin
                    if (w_ready)
                        r_beat_cnt <= (r_beat_cnt == r_w_len) ? '0 : r_beat_cnt + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_w_burst_split.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dma_w_burst_split
// Purpose  : Self-checking bench for dma_w_burst_split. Data beats are random;
//            expected bursts come from an arithmetic model of the 4 KB / FIFO
//            depth split, and beat data is matched against the fed sequence.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_w_burst_split;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LW    = 8;
    localparam int FD    = 4;
    localparam int NW    = 16;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << FD;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start;
    logic [AW-1:0] cfg_addr;
    logic [NW-1:0] cfg_nbeats;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_strb;
    logic          in_ready;
    logic          w_valid;
    logic [AW-1:0] w_addr;
    logic [LW-1:0] w_len;
    logic [DW-1:0] w_wdata;
    logic [SW-1:0] w_wstrb;
    logic          w_ready;
    logic          w_dma_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q_baddr [$];
    int          q_blen  [$];

    always #5 clk = ~clk;

    dma_w_burst_split #(
        .DMA_DATA_WIDTH (DW),
        .ADDR_W         (AW),
        .LEN_W          (LW),
        .FIFO_DEPTH_LOG2(FD),
        .NBEATS_W       (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_addr   (cfg_addr),
        .cfg_nbeats (cfg_nbeats),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_strb    (in_strb),
        .in_ready   (in_ready),
        .w_valid    (w_valid),
        .w_addr     (w_addr),
        .w_len      (w_len),
        .w_wdata    (w_wdata),
        .w_wstrb    (w_wstrb),
        .w_ready    (w_ready),
        .w_dma_ready(w_dma_ready)
    );

    // Reference: walk the transfer, each burst capped by remaining beats,
    // beats left in the current 4 KB page and the FIFO depth.
    task automatic model_bursts(input logic [31:0] addr, input int nbeats);
        logic [31:0] a;
        int rem, to_4k, len;
        a = addr;
        rem = nbeats;
        q_baddr.delete();
        q_blen.delete();
        while (rem > 0) begin
            to_4k = (4096 - int'(a % 4096)) / SW;
            len = rem;
            if (to_4k < len) len = to_4k;
            if (DEPTH < len) len = DEPTH;
            q_baddr.push_back(a);
            q_blen.push_back(len);
            a   = a + 32'(len * SW);
            rem = rem - len;
        end
    endtask

    // One full transfer with a concurrent feeder and engine model, sampled
    // and driven on the falling edge.
    task automatic run_xfer(input logic [31:0] addr, input int nbeats, input int prefill,
                            input int stall, input int wr_pct, input int abort_after);
        logic [31:0] dq [$];
        logic [3:0]  sq [$];
        int fed, popped, done_cnt, bursts, n_exp, cyc, start_cyc, done_cyc;
        int first_lat, pre, burst_beats, exp_fill, first_len;
        bit prev_rdy, prev_wv, started, finished, aborted, wr;
        logic [31:0] cur_a;
        logic [7:0]  cur_l;
        fed = 0; popped = 0; done_cnt = 0; bursts = 0; cyc = 0;
        start_cyc = 0; done_cyc = 0; first_lat = -1; burst_beats = 0;
        started = 0; finished = 0; aborted = 0;
        cur_a = '0; cur_l = '0;
        pre = prefill;
        if (pre > DEPTH) pre = DEPTH;
        if (pre > nbeats) pre = nbeats;
        exp_fill = (nbeats < DEPTH) ? nbeats : DEPTH;
        model_bursts(addr, nbeats);
        n_exp = q_blen.size();
        first_len = (n_exp > 0) ? q_blen[0] : 0;
        for (int i = 0; i < nbeats; i++) begin
            dq.push_back($urandom);
            sq.push_back(4'($urandom));
        end
        in_valid = 0; w_ready = 0; cfg_start = 0; w_dma_ready = 1;
        @(negedge clk);
        prev_rdy = in_ready;
        prev_wv  = w_valid;
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (in_valid && prev_rdy) begin
                fed++;
                in_valid = 0;
            end
            cfg_start = 0;
            if (abort_after >= 0 && popped >= abort_after) begin
                w_ready = 0;
                rst = 1;
                #1;
                n_checks++;
                if (w_valid !== 1'b0) $display("FAIL abort_w_valid: got %b want 0", w_valid);
                else n_pass++;
                n_checks++;
                if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
                else n_pass++;
                n_checks++;
                if (in_ready !== 1'b1 || done !== 1'b0)
                    $display("FAIL abort_fifo_done: in_ready=%b done=%b want 1/0", in_ready, done);
                else n_pass++;
                aborted  = 1;
                finished = 1;
            end else begin
                if (!started && fed >= pre) begin
                    cfg_start  = 1;
                    cfg_addr   = addr;
                    cfg_nbeats = 16'(nbeats);
                    started    = 1;
                    start_cyc  = cyc;
                end
                if (started && stall > 0 && cyc - start_cyc == stall) begin
                    n_checks++;
                    if (fed != exp_fill || in_ready !== (exp_fill < DEPTH) || w_valid !== 1'b0)
                        $display("FAIL stall_fill: accepted=%0d in_ready=%b w_valid=%b want %0d/%b/0",
                                 fed, in_ready, w_valid, exp_fill, exp_fill < DEPTH);
                    else n_pass++;
                end
                w_dma_ready = !(started && (cyc - start_cyc) < stall);
                if (w_valid && !prev_wv) begin
                    bursts++;
                    burst_beats = 0;
                    if (first_lat < 0) first_lat = cyc - start_cyc;
                    n_checks++;
                    if (q_baddr.size() == 0) begin
                        $display("FAIL burst_hdr: unexpected burst addr=%h len=%0d", w_addr, w_len);
                    end else begin
                        cur_a = q_baddr.pop_front();
                        cur_l = 8'(q_blen.pop_front() - 1);
                        if (w_addr !== cur_a || w_len !== cur_l)
                            $display("FAIL burst_hdr: got addr=%h len=%0d want addr=%h len=%0d",
                                     w_addr, w_len, cur_a, cur_l);
                        else n_pass++;
                    end
                end
                if (!w_valid && prev_wv) begin
                    n_checks++;
                    if (burst_beats != int'(cur_l) + 1)
                        $display("FAIL burst_beats: got %0d want %0d", burst_beats, int'(cur_l) + 1);
                    else n_pass++;
                end
                wr = ($urandom_range(0, 99) < wr_pct);
                if (w_valid && wr) begin
                    n_checks++;
                    if (popped >= nbeats)
                        $display("FAIL beat_data: extra beat %0d data=%h", popped, w_wdata);
                    else if (w_wdata !== dq[popped] || w_wstrb !== sq[popped] ||
                             w_addr !== cur_a || w_len !== cur_l)
                        $display("FAIL beat_data: beat %0d got %h/%h addr=%h len=%0d want %h/%h addr=%h len=%0d",
                                 popped, w_wdata, w_wstrb, w_addr, w_len, dq[popped], sq[popped], cur_a, cur_l);
                    else n_pass++;
                    popped++;
                    burst_beats++;
                end
                w_ready = wr;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    finished = 1;
                end
                if (!in_valid && fed < nbeats && $urandom_range(0, 3) != 0) begin
                    in_valid = 1;
                    in_data  = dq[fed];
                    in_strb  = sq[fed];
                end
            end
            prev_rdy = in_ready;
            prev_wv  = w_valid;
        end
        if (aborted) begin
            @(negedge clk);
            rst = 0;
            in_valid = 0;
            w_dma_ready = 1;
        end else begin
            w_ready = 0;
            in_valid = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done) done_cnt++;
            end
            n_checks++;
            if (!finished) $display("FAIL xfer_timeout: no done after %0d cycles", cyc);
            else n_pass++;
            n_checks++;
            if (done_cnt != 1) $display("FAIL done_pulses: got %0d want 1", done_cnt);
            else n_pass++;
            n_checks++;
            if (popped != nbeats || fed != nbeats)
                $display("FAIL beat_count: popped=%0d fed=%0d want %0d", popped, fed, nbeats);
            else n_pass++;
            n_checks++;
            if (bursts != n_exp) $display("FAIL burst_count: got %0d want %0d", bursts, n_exp);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
            else n_pass++;
            if (nbeats > 0 && pre >= first_len && stall == 0) begin
                n_checks++;
                if (first_lat != 3) $display("FAIL first_latency: got %0d want 3", first_lat);
                else n_pass++;
            end
            if (nbeats == 0) begin
                n_checks++;
                if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2)
                    $display("FAIL zero_done_latency: got %0d want 1..2", done_cyc - start_cyc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; cfg_start = 0; cfg_addr = '0; cfg_nbeats = '0;
        in_valid = 0; in_data = '0; in_strb = '0; w_ready = 0; w_dma_ready = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0)
            $display("FAIL reset_ctrl: busy=%b done=%b w_valid=%b want 0/0/0", busy, done, w_valid);
        else n_pass++;
        n_checks++;
        if (w_addr !== '0 || w_len !== '0)
            $display("FAIL reset_regs: w_addr=%h w_len=%h want 0/0", w_addr, w_len);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();  run_xfer(32'h0000_1000, 4, 4, 0, 100, -1);  endtask
    task automatic test_4k_cross();      run_xfer(32'h0000_0FF8, 8, 8, 0, 100, -1);  endtask
    task automatic test_depth_split();   run_xfer(32'h0000_0000, 40, 16, 0, 70, -1); endtask
    task automatic test_backpressure();  run_xfer(32'h0000_0000, 20, 0, 60, 100, -1); endtask
    task automatic test_zero_len();      run_xfer(32'h0000_0200, 0, 0, 0, 100, -1);  endtask

    task automatic test_reset_mid();
        run_xfer(32'h0000_0000, 8, 8, 0, 100, 3);
        run_xfer(32'h0000_2000, 8, 8, 0, 100, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 8; t++) begin
            a = 32'($urandom_range(0, 7) * 4096 + 4096 - 4 * $urandom_range(1, 40));
            run_xfer(a, $urandom_range(1, 60), $urandom_range(0, 20), 0,
                     $urandom_range(30, 100), -1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_4k_cross();
        test_depth_split();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
